// File: rtl/mult_manager.sv
// Pipelined RV32M multiplier with per-stage rd/occupancy tracking for hazard
// detection and a ready-handshaked writeback port.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 3
`endif

module mult_manager #(
  parameter int STAGES = `MULT_PPL_STAGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [1:0]             issue_op_i,
  input  logic [31:0]            issue_rs1_i,
  input  logic [31:0]            issue_rs2_i,
  input  logic [4:0]             issue_rd_i,
  output logic [STAGES-1:0][4:0] rd_addrs_o,
  output logic [STAGES-1:0]      uses_o,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [31:0]            wb_data_o,
  output logic                   busy_o
);

  logic [STAGES-1:0]       use_q;
  logic [STAGES-1:0][4:0]  rd_q;
  logic [STAGES-1:1][31:0] res_q;
  logic [32:0]             a_q;
  logic [32:0]             b_q;
  logic                    hi_q;

  logic        advance;
  logic        fire;
  logic        rs1_signed;
  logic        rs2_signed;
  logic [63:0] prod;
  logic [31:0] prod_sel;

  assign advance       = !use_q[STAGES-1] || wb_ready_i;
  assign issue_ready_o = advance;
  assign fire          = issue_valid_i && advance;

  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  assign rs1_signed = (issue_op_i == 2'b01) || (issue_op_i == 2'b10);
  assign rs2_signed = (issue_op_i == 2'b01);

  // The low 64 bits of the 66-bit signed product equal the low 64 bits of
  // the sign-extended operands multiplied modulo 2^64.
  always_comb begin
    prod     = {{31{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q};
    prod_sel = hi_q ? prod[63:32] : prod[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      use_q <= '0;
      rd_q  <= '0;
      res_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= 1'b0;
    end else if (advance) begin
      // rd=0 completes the handshake but never occupies a tracked slot
      use_q[0] <= fire && (issue_rd_i != 5'd0);
      rd_q[0]  <= fire ? issue_rd_i : 5'd0;
      if (fire) begin
        a_q  <= {rs1_signed & issue_rs1_i[31], issue_rs1_i};
        b_q  <= {rs2_signed & issue_rs2_i[31], issue_rs2_i};
        hi_q <= (issue_op_i != 2'b00);
      end
      for (int k = 1; k < STAGES; k++) begin
        use_q[k] <= use_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
      res_q[1] <= prod_sel;
      for (int k = 2; k < STAGES; k++) begin
        res_q[k] <= res_q[k-1];
      end
    end
  end

  assign uses_o     = use_q;
  assign rd_addrs_o = rd_q;
  assign busy_o     = |use_q;
  assign wb_valid_o = use_q[STAGES-1];
  assign wb_rd_o    = rd_q[STAGES-1];
  assign wb_data_o  = use_q[STAGES-1] ? res_q[STAGES-1] : 32'd0;

endmodule

// File: tb/tb_mult_manager.sv
// Self-checking bench for mult_manager: directed scenarios plus random traffic
// checked against an in-order result queue computed with plain arithmetic.
`timescale 1ns/1ps

module tb_mult_manager;
  localparam int S = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [1:0]        issue_op_i;
  logic [31:0]       issue_rs1_i;
  logic [31:0]       issue_rs2_i;
  logic [4:0]        issue_rd_i;
  logic [S-1:0][4:0] rd_addrs_o;
  logic [S-1:0]      uses_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [4:0]        wb_rd_o;
  logic [31:0]       wb_data_o;
  logic              busy_o;

  mult_manager #(.STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rd_i(issue_rd_i), .rd_addrs_o(rd_addrs_o), .uses_o(uses_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V reference: signedness per op, 64-bit product, pick half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Inputs are already driven; sample pre-edge handshakes, advance one edge.
  task automatic cycle();
    wb_t e;
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (wb_valid_o && wb_ready_i) begin
        if (exp_q.size() == 0) begin
          check_val("wb_spurious", 64'(wb_valid_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("wb_rd", 64'(wb_rd_o), 64'(e.rd));
          check_val("wb_data", 64'(wb_data_o), 64'(e.data));
        end
      end
      if (issue_valid_i && issue_ready_o && issue_rd_i != 5'd0) begin
        e.rd   = issue_rd_i;
        e.data = ref_mul(issue_op_i, issue_rs1_i, issue_rs2_i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    issue_valid_i = v; issue_op_i = op; issue_rs1_i = a; issue_rs2_i = b; issue_rd_i = rd;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    issue_valid_i = 1'b0;
    wb_ready_i    = 1'b1;
    while ((exp_q.size() != 0 || busy_o) && n < 50) begin
      cycle();
      n++;
    end
    check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] hold_data;
    logic [4:0]  hold_rd;
    rst = 1'b1; wb_ready_i = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    cycle(); cycle();
    check_val("rst_uses", 64'(uses_o), 64'd0);
    check_val("rst_rds", 64'(rd_addrs_o), 64'd0);
    check_val("rst_wbv", 64'(wb_valid_o), 64'd0);
    check_val("rst_wbd", 64'(wb_data_o), 64'd0);
    rst = 1'b0;
    cycle();

    // single MUL, walk through the stages
    drive(1'b1, 2'b00, 32'd7, 32'd6, 5'd5);
    check_val("t1_ready", 64'(issue_ready_o), 64'd1);
    cycle();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int k = 0; k < S; k++) begin
      check_val("t1_uses", 64'(uses_o), 64'(1 << k));
      check_val("t1_rd", 64'(rd_addrs_o[k]), 64'd5);
      check_val("t1_wbv", 64'(wb_valid_o), (k == S-1) ? 64'd1 : 64'd0);
      if (k == S-1) begin
        check_val("t1_wbrd", 64'(wb_rd_o), 64'd5);
        check_val("t1_wbdata", 64'(wb_data_o), 64'd42);
      end
      cycle();
    end
    check_val("t1_uses_end", 64'(uses_o), 64'd0);
    check_val("t1_rds_end", 64'(rd_addrs_o), 64'd0);

    // four ops back to back on all-ones operands
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 1));
      check_val("t2_ready", 64'(issue_ready_o), 64'd1);
      cycle();
    end
    check_val("t2_ref_mulhu", 64'(exp_q[exp_q.size()-1].data), 64'hFFFFFFFE);
    for (int i = 0; i < 4 && i < exp_q.size(); i++) begin
      check_val("t2_queue_rd", 64'(exp_q[i].rd), 64'(i + 1 + 4 - exp_q.size()));
    end
    drain("t2");

    // rd=0 never becomes visible
    drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd0);
    check_val("t3_ready", 64'(issue_ready_o), 64'd1);
    cycle();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int k = 0; k < S + 1; k++) begin
      check_val("t3_uses", 64'(uses_o), 64'd0);
      check_val("t3_rds", 64'(rd_addrs_o), 64'd0);
      check_val("t3_wbv", 64'(wb_valid_o), 64'd0);
      cycle();
    end

    // fill, then stall writeback for 4 cycles
    wb_ready_i = 1'b0;
    for (int i = 0; i < S; i++) begin
      drive(1'b1, 2'b00, 32'(100 + i), 32'd3, 5'(10 + i));
      cycle();
    end
    drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd20);
    hold_rd   = exp_q[0].rd;
    hold_data = exp_q[0].data;
    for (int c = 0; c < 4; c++) begin
      check_val("t4_ready", 64'(issue_ready_o), 64'd0);
      check_val("t4_uses", 64'(uses_o), 64'((1 << S) - 1));
      check_val("t4_wbv", 64'(wb_valid_o), 64'd1);
      check_val("t4_wbrd", 64'(wb_rd_o), 64'(hold_rd));
      check_val("t4_wbdata", 64'(wb_data_o), 64'(hold_data));
      cycle();
    end
    check_val("t4_qsize", 64'(exp_q.size()), 64'(S));
    drain("t4");

    // reset with two entries in flight
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, 32'h12345678, 32'h9abcdef0, 5'(25 + i));
      cycle();
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("t5_uses", 64'(uses_o), 64'd0);
    check_val("t5_wbv", 64'(wb_valid_o), 64'd0);
    check_val("t5_wbd", 64'(wb_data_o), 64'd0);
    for (int k = 0; k < S + 1; k++) begin
      check_val("t5_no_wb", 64'(wb_valid_o), 64'd0);
      cycle();
    end

    // MULH / MUL corner
    drive(1'b1, 2'b01, 32'h80000000, 32'h80000000, 5'd7);
    cycle();
    drive(1'b1, 2'b00, 32'h80000000, 32'h80000000, 5'd8);
    cycle();
    check_val("t6_ref_mulh", 64'(exp_q[0].data), 64'h40000000);
    check_val("t6_ref_mul", 64'(exp_q[1].data), 64'h0);
    drain("t6");

    // random traffic
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 7) == 0) issue_rs1_i = 32'h80000000;
      wb_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
      check_val("rnd_busy", 64'(busy_o), 64'(exp_q.size() != 0));
      for (int k = 0; k < S; k++) begin
        if (!uses_o[k]) check_val("rnd_rd_empty", 64'(rd_addrs_o[k]), 64'd0);
      end
    end
    drain("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mult_manager.md
Name: mult_manager

Overview:
- Pipelined RV32M multiply unit plus in-flight tracker. Sits between the EX-stage issue of MUL/MULH/MULHSU/MULHU and register-file writeback.
- Accepts one multiply per cycle and carries each operation's rd through STAGES pipeline stages.
- Exports per-stage rd addresses and occupancy bits to the downstream multiply stall controller, so ID can stall on hazards against in-flight products.
- Presents finished results on a dedicated writeback port with a ready handshake.

Parameters:
- STAGES, default `MULT_PPL_STAGE (3): number of multiply pipeline stages; issue-to-result latency. Minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- issue_valid_i  in  1  EX presents a multiply this cycle
- issue_ready_o  out  1  unit can accept an issue this cycle
- issue_op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- issue_rs1_i  in  32  operand A
- issue_rs2_i  in  32  operand B
- issue_rd_i  in  5  destination register
- rd_addrs_o  out  5 x [STAGES-1:0]  rd held in each stage; 0 when stage empty
- uses_o  out  STAGES  stage-occupied bits; bit 0 = youngest
- wb_valid_o  out  1  result in last stage is ready for writeback
- wb_ready_i  in  1  regfile write port granted to the multiply unit
- wb_rd_o  out  5  writeback destination
- wb_data_o  out  32  writeback data
- busy_o  out  1  OR of uses_o

Behaviour:
- Reset: uses_o=0, all rd_addrs_o=0, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, all internal operand/product registers cleared.
- Reset asserted mid-operation discards every in-flight entry; none is written back.
- advance = !uses_o[STAGES-1] || wb_ready_i.
- issue_ready_o = advance (combinational).
- Issue fires when issue_valid_i && issue_ready_o at a rising edge.
- On advance, every stage k shifts into stage k+1. Stage 0 loads:
  - the issued entry if issue fires;
  - otherwise an empty entry (use=0, rd=0, data don't-care).
- When advance=0, all stages hold: no shift and no issue.
- rd=0 issue: handshake completes, but stage 0 loads use=0 and rd=0. No writeback and no hazard exposure.
- Invariant: rd_addrs_o[k]==0 whenever uses_o[k]==0; uses_o[k]=1 implies rd_addrs_o[k]!=0.
- Latency: an entry issued at edge t occupies stage k after edge t+k (absent holds). It is visible as wb_valid_o=1 after edge t+STAGES-1. Each hold cycle adds one cycle.
- Back-to-back issues are allowed at full rate; results leave in issue order.
- wb_valid_o = uses_o[STAGES-1]; wb_rd_o = rd_addrs_o[STAGES-1].
- wb_data_o is valid when wb_valid_o=1, and is 0 when the last stage is empty.
- The entry retires on the edge where wb_valid_o && wb_ready_i.
- If the last stage retires and a new issue fires on the same edge, both take effect (full throughput).
- Arithmetic:
  - Extend each operand to 33 bits: rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only; otherwise zero-extend.
  - Form the 66-bit signed product.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
  - The partial-product split across stages is implementation choice; only the latency above is observable.
- Corner cases to match the RISC-V spec:
  - MULH 0x80000000 x 0x80000000 = 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF = 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF = 0xFFFFFFFF.
- busy_o = |uses_o.

Test Plan:
- Reset, then a single MUL rd=5, 7x6 with wb_ready=1 → uses_o walks bits 0..STAGES-1 one per cycle, rd_addrs_o tracks 5. wb_valid=1 with wb_rd=5 and wb_data=42 exactly STAGES-1 cycles after issue; after retire, uses_o=0 and all rd_addrs_o=0.
- Four back-to-back issues, MUL/MULH/MULHSU/MULHU, all with operands 0xFFFFFFFF, rd=1..4 → wb_data sequence 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE on consecutive cycles with rd 1,2,3,4; issue_ready stays high throughout.
- Issue with rd=0 → handshake accepted, uses_o stays 0, rd_addrs_o stays 0, and no wb_valid ever appears.
- Fill the pipe with 3 issues, then hold wb_ready=0 for 4 cycles → issue_ready=0, all stages frozen, wb_valid held with stable rd/data. Raise wb_ready → retire resumes one per cycle with no entry lost or duplicated.
- Assert rst with 2 entries in flight → next cycle uses_o=0, wb_valid=0, wb_data=0, and no writeback of the dropped entries.
- MULH 0x80000000 x 0x80000000 → wb_data=0x40000000; MUL of the same operands → 0x00000000.
